// File: rtl/sweeper_pkg.sv
// -----------------------------------------------------------------------------
// sweeper_pkg
// Shared definitions for the truth-table sweeper: FSM state encoding and the
// default function-unit width with its derived vector count.
// -----------------------------------------------------------------------------
package sweeper_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE
   } state_e;

   localparam int N_IN_DEF  = 4;
   localparam int N_VEC_DEF = 1 << N_IN_DEF;

endpackage : sweeper_pkg

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the host control/result signals and the function-unit stimulus pair.
//   master : host side plus function unit (drives start, abort, exp_tt, dut_f)
//   slave  : the sweeper (drives dut_in, busy, done and the published results)
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if
   import sweeper_pkg::*;
#(
   parameter int N_IN = N_IN_DEF
);
   localparam int N_VEC = 1 << N_IN;

   logic              start;
   logic              abort;
   logic [N_VEC-1:0]  exp_tt;
   logic [N_IN-1:0]   dut_in;
   logic              dut_f;
   logic              busy;
   logic              done;
   logic [N_VEC-1:0]  tt;
   logic              pass;
   logic [N_IN:0]     mismatch_cnt;
   logic              fail_valid;
   logic [N_IN-1:0]   first_fail_idx;

   modport master (
      output start, abort, exp_tt, dut_f,
      input  dut_in, busy, done, tt, pass, mismatch_cnt, fail_valid, first_fail_idx
   );

   modport slave (
      input  start, abort, exp_tt, dut_f,
      output dut_in, busy, done, tt, pass, mismatch_cnt, fail_valid, first_fail_idx
   );

endinterface : truth_table_sweeper_if

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Counts the dwell cycles of one vector. `load` restarts the count at zero,
// `en` advances it, and `expire` flags the last dwell cycle (count == SETTLE-1).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart count
//   en         : advance count
//   expire     : current cycle is the last settle cycle
// -----------------------------------------------------------------------------
module settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);
   // Count never needs to hold more than SETTLE-1.
   localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   logic [W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt_q <= '0;
      else if (load) cnt_q <= '0;
      else if (en)   cnt_q <= cnt_q + 1'b1;
   end

   assign expire = (cnt_q == W'(SETTLE - 1));

endmodule : settle_timer

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives every input vector of an N_IN-input function unit in ascending order,
// waits SETTLE cycles per vector, captures dut_f into a truth table and scores
// it against the expected table latched at start.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of truth_table_sweeper_if (control, stimulus, results)
// Published results change only when a sweep completes; an abort leaves them
// untouched.
// -----------------------------------------------------------------------------
module truth_table_sweeper
   import sweeper_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_sweeper_if.slave  bus
);
   localparam int               N_VEC    = 1 << N_IN;
   localparam logic [N_IN-1:0]  LAST_IDX = {N_IN{1'b1}};

   state_e state_q, state_d;

   // FSM strobes
   logic accept, capture, abort_run, timer_load, timer_en, expire, last;

   // Sweep working set
   logic [N_IN-1:0]  idx_q;
   logic [N_VEC-1:0] exp_q;
   logic [N_VEC-1:0] work_tt_q,    work_tt_d;
   logic [N_IN:0]    work_cnt_q,   work_cnt_d;
   logic [N_IN-1:0]  work_first_q, work_first_d;
   logic             work_fail_q,  work_fail_d;
   logic             miss;

   // Published outputs
   logic             busy_q, done_q, pass_q, fail_q;
   logic [N_VEC-1:0] tt_q;
   logic [N_IN:0]    cnt_q;
   logic [N_IN-1:0]  first_q;

   settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (timer_load),
      .en     (timer_en),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      capture    = 1'b0;
      abort_run  = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // abort outranks start, even when nothing is running
            if (bus.start && !bus.abort) begin
               accept     = 1'b1;
               timer_load = 1'b1;
               state_d    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (bus.abort) begin
               abort_run = 1'b1;
               state_d   = S_IDLE;
            end else begin
               timer_en = 1'b1;
               if (expire) state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (bus.abort) begin
               abort_run = 1'b1;
               state_d   = S_IDLE;
            end else begin
               capture = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  timer_load = 1'b1;
                  state_d    = S_SETTLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign last = capture && (idx_q == LAST_IDX);

   // Working set after folding in the current capture; also what gets
   // published on the last vector, so the final compare is included.
   always_comb begin
      miss               = bus.dut_f ^ exp_q[idx_q];
      work_tt_d          = work_tt_q;
      work_tt_d[idx_q]   = bus.dut_f;
      work_cnt_d         = work_cnt_q + {{N_IN{1'b0}}, miss};
      work_first_d       = (miss && !work_fail_q) ? idx_q : work_first_q;
      work_fail_d        = work_fail_q | miss;
   end

   // NOTE: the truth-table registers are reset like any other flop because
   // the published table must read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         exp_q        <= '0;
         work_tt_q    <= '0;
         work_cnt_q   <= '0;
         work_first_q <= '0;
         work_fail_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tt_q         <= '0;
         pass_q       <= 1'b0;
         cnt_q        <= '0;
         fail_q       <= 1'b0;
         first_q      <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            exp_q        <= bus.exp_tt;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            work_tt_q    <= '0;
            work_cnt_q   <= '0;
            work_first_q <= '0;
            work_fail_q  <= 1'b0;
         end else if (abort_run) begin
            idx_q  <= '0;
            busy_q <= 1'b0;
         end else if (capture) begin
            work_tt_q    <= work_tt_d;
            work_cnt_q   <= work_cnt_d;
            work_first_q <= work_first_d;
            work_fail_q  <= work_fail_d;
            if (last) begin
               idx_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               tt_q    <= work_tt_d;
               pass_q  <= (work_cnt_d == '0);
               cnt_q   <= work_cnt_d;
               fail_q  <= work_fail_d;
               first_q <= work_first_d;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   assign bus.dut_in         = idx_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.tt             = tt_q;
   assign bus.pass           = pass_q;
   assign bus.mismatch_cnt   = cnt_q;
   assign bus.fail_valid     = fail_q;
   assign bus.first_fail_idx = first_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers share one function table: u_dut_a (SETTLE=1) talks to either a
// combinational unit or a two-stage registered unit; u_dut_b (SETTLE=3) always
// talks to the registered unit. Expected results come from scoring the table
// the unit should present against exp_tt with plain loops.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;
   import sweeper_pkg::*;

   localparam int N_IN  = N_IN_DEF;
   localparam int N_VEC = 1 << N_IN;
   localparam logic [N_VEC-1:0] XOR4 = 16'h6996;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [N_VEC-1:0] fn_tt      = '0;
   logic             reg_mode_a = 1'b0;
   logic             a_d1 = 1'b0, a_d2 = 1'b0, b_d1 = 1'b0, b_d2 = 1'b0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(N_IN)) if_a ();
   truth_table_sweeper_if #(.N_IN(N_IN)) if_b ();

   truth_table_sweeper #(.N_IN(N_IN), .SETTLE(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a)
   );
   truth_table_sweeper #(.N_IN(N_IN), .SETTLE(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b)
   );

   // Function units: combinational lookup, or the same lookup behind two flops.
   always @(posedge clk) begin
      a_d1 <= fn_tt[if_a.dut_in];
      a_d2 <= a_d1;
      b_d1 <= fn_tt[if_b.dut_in];
      b_d2 <= b_d1;
   end
   assign if_a.dut_f = reg_mode_a ? a_d2 : fn_tt[if_a.dut_in];
   assign if_b.dut_f = b_d2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from the start edge until done is seen; -1 if the budget runs out.
   task automatic wait_done_a(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (if_a.done) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic wait_done_b(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (if_b.done) begin
            cyc = k;
            break;
         end
      end
   endtask

   // Reference scoring: number of differing bits and lowest differing index.
   function automatic void score(input logic [N_VEC-1:0] cap, input logic [N_VEC-1:0] exp,
                                 output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int i = 0; i < N_VEC; i++) begin
         if (cap[i] != exp[i]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      if (first < 0) first = 0;
   endfunction

   task automatic check_pub_a(input string tag, input logic [N_VEC-1:0] cap, input logic [N_VEC-1:0] exp);
      int cnt, first;
      score(cap, exp, cnt, first);
      check({tag, "_tt"},    if_a.tt, cap);
      check({tag, "_cnt"},   if_a.mismatch_cnt, cnt);
      check({tag, "_pass"},  if_a.pass, (cnt == 0));
      check({tag, "_fail"},  if_a.fail_valid, (cnt != 0));
      check({tag, "_first"}, if_a.first_fail_idx, first);
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, "_dut_in"}, if_a.dut_in, 0);
      check({tag, "_busy"},   if_a.busy, 0);
      check({tag, "_done"},   if_a.done, 0);
      check({tag, "_tt"},     if_a.tt, 0);
      check({tag, "_pass"},   if_a.pass, 0);
      check({tag, "_cnt"},    if_a.mismatch_cnt, 0);
      check({tag, "_fail"},   if_a.fail_valid, 0);
      check({tag, "_first"},  if_a.first_fail_idx, 0);
   endtask

   // Full sweep on u_dut_a with latency, busy/done framing and result checks.
   task automatic sweep_a(input string tag, input logic [N_VEC-1:0] exp, input logic [N_VEC-1:0] cap);
      int cyc;
      if_a.exp_tt = exp;
      if_a.start  = 1'b1;
      tick();
      if_a.start  = 1'b0;
      check({tag, "_busy_on"}, if_a.busy, 1);
      wait_done_a(cyc);
      check({tag, "_lat"}, cyc, 2 * N_VEC);
      check({tag, "_busy_off"}, if_a.busy, 0);
      check_pub_a(tag, cap, exp);
      tick();
      check({tag, "_done_pulse"}, if_a.done, 0);
   endtask

   initial begin
      int                cyc;
      int                done_seen;
      logic [N_VEC-1:0]  exp, cap;

      rst_n       = 1'b0;
      if_a.start  = 1'b0;
      if_a.abort  = 1'b0;
      if_a.exp_tt = '0;
      if_b.start  = 1'b0;
      if_b.abort  = 1'b0;
      if_b.exp_tt = '0;
      #1;
      check_zero_a("rst");
      check("rst_b_busy", if_b.busy, 0);
      #20;
      rst_n = 1'b1;
      tick();

      // XOR4 unit: exact match, single-bit disagreement, all-zero expectation
      fn_tt = XOR4;
      sweep_a("xor_ok", XOR4, XOR4);
      sweep_a("xor_6997", 16'h6997, XOR4);
      check("xor_6997_first_lit", if_a.first_fail_idx, 0);
      sweep_a("xor_zero", 16'h0000, XOR4);
      check("xor_zero_cnt_lit", if_a.mismatch_cnt, 8);
      check("xor_zero_first_lit", if_a.first_fail_idx, 1);

      // Random functions against matching, near-matching and random tables
      for (int i = 0; i < 6; i++) begin
         fn_tt = N_VEC'($urandom());
         case (i % 3)
            0:       exp = fn_tt;
            1:       exp = fn_tt ^ (N_VEC'(1) << $urandom_range(N_VEC - 1, 0));
            default: exp = N_VEC'($urandom());
         endcase
         sweep_a($sformatf("rnd%0d", i), exp, fn_tt);
      end

      // Registered unit with only two dwell cycles per vector returns the
      // previous vector's result (vector 0 sees the idle vector 0).
      fn_tt      = XOR4;
      reg_mode_a = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < N_VEC; i++) cap[i] = fn_tt[(i == 0) ? 0 : i - 1];
      sweep_a("reg_s1", XOR4, cap);
      check("reg_s1_not_pass", if_a.pass, 0);
      reg_mode_a = 1'b0;

      // Same registered unit, SETTLE=3 instance
      if_b.exp_tt = XOR4;
      if_b.start  = 1'b1;
      tick();
      if_b.start  = 1'b0;
      wait_done_b(cyc);
      check("reg_s3_lat", cyc, 4 * N_VEC);
      check("reg_s3_tt", if_b.tt, XOR4);
      check("reg_s3_pass", if_b.pass, 1);
      check("reg_s3_cnt", if_b.mismatch_cnt, 0);

      // Leave a passing result published
      sweep_a("pre", XOR4, XOR4);

      // start pulsed mid-sweep with a different table: ignored
      if_a.exp_tt = XOR4;
      if_a.start  = 1'b1;
      tick();
      if_a.start  = 1'b0;
      repeat (9) tick();
      if_a.exp_tt = 16'h0000;
      if_a.start  = 1'b1;
      tick();
      if_a.start  = 1'b0;
      wait_done_a(cyc);
      check("midstart_lat", cyc, 2 * N_VEC - 10);
      check_pub_a("midstart", XOR4, XOR4);
      tick();

      // abort mid-sweep: busy drops, no done, results untouched
      if_a.exp_tt = 16'h0000;
      if_a.start  = 1'b1;
      tick();
      if_a.start  = 1'b0;
      repeat (9) tick();
      if_a.abort = 1'b1;
      tick();
      if_a.abort = 1'b0;
      check("abort_busy", if_a.busy, 0);
      check("abort_dut_in", if_a.dut_in, 0);
      done_seen = 0;
      for (int k = 0; k < 3 * N_VEC; k++) begin
         tick();
         if (if_a.done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      check_pub_a("abort_keep", XOR4, XOR4);

      // abort and start together in IDLE: nothing starts
      if_a.start = 1'b1;
      if_a.abort = 1'b1;
      tick();
      if_a.start = 1'b0;
      if_a.abort = 1'b0;
      check("abort_start_idle", if_a.busy, 0);

      // Reset mid-sweep clears everything without a clock edge
      sweep_a("pre_rst", 16'h0000, XOR4);
      if_a.exp_tt = XOR4;
      if_a.start  = 1'b1;
      tick();
      if_a.start  = 1'b0;
      repeat (11) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_a("midrst");
      #2;
      rst_n = 1'b1;
      tick();
      sweep_a("post_rst", XOR4, XOR4);

      // start held through the done cycle: a second sweep begins right after
      if_a.exp_tt = XOR4;
      if_a.start  = 1'b1;
      tick();
      wait_done_a(cyc);
      check("b2b_lat1", cyc, 2 * N_VEC);
      tick();
      if_a.start = 1'b0;
      check("b2b_busy", if_a.busy, 1);
      check("b2b_done_clr", if_a.done, 0);
      wait_done_a(cyc);
      check("b2b_lat2", cyc, 2 * N_VEC);
      check_pub_a("b2b", XOR4, XOR4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_truth_table_sweeper
